front_line_buffer: RTL

FRONT_LINE_BUFFER -- requirements
Module: front_line_buffer

---
 rtl/front_lb_pkg.sv | 20 ++
 rtl/front_line_buffer_ram.sv | 37 +++
 rtl/front_line_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/front_lb_pkg.sv
// Shared constants, display FSM states and helpers for the front-layer line buffer.
// Both the top level and the bank RAM take their defaults from here.
package front_lb_pkg;

  localparam int         ADDR_W = 9;
  localparam int         PIX_W  = 8;
  localparam logic [7:0] TRANSP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CLEAR
  } disp_state_e;

  // Pixel index 3'b111 marks a see-through sprite pixel that must not land in the buffer.
  function automatic logic isTransparent(input logic [PIX_W-1:0] code);
    return code[2:0] == 3'b111;
  endfunction

endpackage

// File: rtl/front_line_buffer_ram.sv
// One line-buffer bank: 2^ADDR_W x PIX_W memory with a synchronous read.
// It has one write port for the fill side (A) and one read/write port for the display side (B).
module lb_bank_ram
  import front_lb_pkg::*;
#(
  parameter int ADDR_W = front_lb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [PIX_W-1:0]  a_wdata_i,
  input  logic              b_re_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [PIX_W-1:0]  b_wdata_i,
  output logic [PIX_W-1:0]  b_rdata_o
);

  logic [PIX_W-1:0] mem_q [2**ADDR_W];
  logic [PIX_W-1:0] rdata_q;

  // Contents are deliberately never reset; the display side erases them as it reads.
  always_ff @(posedge clk) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    if (b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end
    if (b_re_i) begin
      rdata_q <= mem_q[b_addr_i];
    end
  end

  assign b_rdata_o = rdata_q;

endmodule

// File: rtl/front_line_buffer.sv
// Double-banked sprite line buffer: one bank is filled by the shifter while the other
// is read out for display and erased to TRANSP behind the read.
module front_line_buffer
  import front_lb_pkg::*;
#(
  parameter int         ADDR_W = front_lb_pkg::ADDR_W,
  parameter logic [7:0] TRANSP = front_lb_pkg::TRANSP
) (
  input  logic       clk,
  input  logic       VIDEO_RSTn,
  input  logic       LC,
  input  logic [8:0] FL_Y,
  input  logic       pix_cen,
  input  logic [7:0] FD,
  input  logic       line_swap,
  input  logic       disp_start,
  input  logic       disp_cen,
  output logic [7:0] pix_out,
  output logic       pix_opaque,
  output logic       fill_bank
);

  logic              fillBank_q, fillBank_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0] fillAddr;
  logic              fillWe;

  disp_state_e       state_q;
  logic              dispBank_q;
  logic              restart_q;
  logic [ADDR_W-1:0] rdAddr_q;
  logic [PIX_W-1:0]  pixOut_q;
  logic              pixOpaque_q;

  logic [ADDR_W-1:0] readAddr;
  logic [ADDR_W-1:0] dispAddr;
  logic              startRead;
  logic [1:0]        bankAWe, bankBRe, bankBWe;
  logic [PIX_W-1:0]  bankRdata [2];
  logic [PIX_W-1:0]  rdData;

  // An LC in the same clk as pix_cen redirects that very pixel to FL_Y.
  always_comb begin
    fillAddr   = LC ? FL_Y[ADDR_W-1:0] : wrAddr_q;
    fillWe     = pix_cen && !isTransparent(FD);
    wrAddr_d   = wrAddr_q;
    if (pix_cen) begin
      wrAddr_d = fillAddr + ADDR_W'(1);
    end else if (LC) begin
      wrAddr_d = fillAddr;
    end
    fillBank_d = fillBank_q ^ line_swap;
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      fillBank_q <= 1'b0;
      wrAddr_q   <= '0;
    end else begin
      fillBank_q <= fillBank_d;
      wrAddr_q   <= wrAddr_d;
    end
  end

  // Bank writes use the pre-swap fill_bank; the display port follows the bank latched at READ entry.
  always_comb begin
    startRead = (state_q == IDLE) && disp_cen;
    readAddr  = disp_start ? '0 : rdAddr_q;
    dispAddr  = (state_q == READ) ? rdAddr_q : readAddr;
    bankAWe   = fillWe ? (fillBank_q ? 2'b10 : 2'b01) : 2'b00;
    bankBRe   = startRead ? (fillBank_q ? 2'b01 : 2'b10) : 2'b00;
    bankBWe   = (state_q == READ) ? (dispBank_q ? 2'b10 : 2'b01) : 2'b00;
    rdData    = bankRdata[dispBank_q];
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    lb_bank_ram #(
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk      (clk),
      .a_we_i   (bankAWe[g]),
      .a_addr_i (fillAddr),
      .a_wdata_i(FD),
      .b_re_i   (bankBRe[g]),
      .b_we_i   (bankBWe[g]),
      .b_addr_i (dispAddr),
      .b_wdata_i(TRANSP),
      .b_rdata_o(bankRdata[g])
    );
  end

  // A disp_start seen mid-operation is remembered so the address restarts once the clear is done.
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      state_q     <= IDLE;
      rdAddr_q    <= '0;
      dispBank_q  <= 1'b1;
      restart_q   <= 1'b0;
      pixOut_q    <= TRANSP;
      pixOpaque_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (disp_cen) begin
            state_q    <= READ;
            rdAddr_q   <= readAddr;
            dispBank_q <= ~fillBank_q;
          end else if (disp_start) begin
            rdAddr_q   <= '0;
          end
        end
        READ: begin
          state_q     <= CLEAR;
          pixOut_q    <= rdData;
          pixOpaque_q <= (rdData != TRANSP);
          restart_q   <= disp_start;
        end
        CLEAR: begin
          state_q   <= IDLE;
          restart_q <= 1'b0;
          rdAddr_q  <= (disp_start || restart_q) ? '0 : rdAddr_q + ADDR_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_out    = pixOut_q;
  assign pix_opaque = pixOpaque_q;
  assign fill_bank  = fillBank_q;

endmodule
